// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_operand_stage
// Brief    : D->E pipeline register with E/M operand forwarding and
//            load-use stall / bubble insertion ahead of the ALU.
// Revision : 1.0 - initial release
// ============================================================================
module alu_operand_stage #(
    parameter int RW = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          d_valid,
    input  logic [31:0]   d_qa,
    input  logic [31:0]   d_qb,
    input  logic [31:0]   d_imm,
    input  logic [4:0]    d_sa,
    input  logic [3:0]    d_aluc,
    input  logic [RW-1:0] d_rs,
    input  logic [RW-1:0] d_rt,
    input  logic [RW-1:0] d_rn,
    input  logic          d_uses_rs,
    input  logic          d_uses_rt,
    input  logic          d_aluimm,
    input  logic          d_shift,
    input  logic          d_wreg,
    input  logic          d_m2reg,
    input  logic          d_wmem,
    input  logic          flush,
    input  logic [31:0]   ex_alu,
    input  logic [RW-1:0] m_rn,
    input  logic          m_wreg,
    input  logic [31:0]   m_data,
    output logic          stall_req,
    output logic          e_valid,
    output logic          e_wreg,
    output logic          e_m2reg,
    output logic          e_wmem,
    output logic [31:0]   e_a,
    output logic [31:0]   e_b,
    output logic [3:0]    e_aluc,
    output logic [RW-1:0] e_rn,
    output logic [31:0]   e_st_data
);

    localparam logic [RW-1:0] c_R0 = '0;

    logic          r_valid_q, r_wreg_q, r_m2reg_q, r_wmem_q;
    logic [31:0]   r_a_q, r_b_q, r_st_q;
    logic [3:0]    r_aluc_q;
    logic [RW-1:0] r_rn_q;

    logic          w_valid_d, w_wreg_d, w_m2reg_d, w_wmem_d;
    logic [31:0]   w_a_d, w_b_d, w_st_d;
    logic [3:0]    w_aluc_d;
    logic [RW-1:0] w_rn_d;

    logic          w_e_fwd_ok, w_m_fwd_ok, w_e_load, w_stall, w_bubble;
    logic [31:0]   w_fa, w_fb;

    // A load in E has no result yet, so it cannot forward; it stalls instead.
    assign w_e_fwd_ok = r_valid_q & r_wreg_q & ~r_m2reg_q & (r_rn_q != c_R0);
    assign w_m_fwd_ok = m_wreg & (m_rn != c_R0);
    assign w_e_load   = r_valid_q & r_wreg_q & r_m2reg_q & (r_rn_q != c_R0);

    assign w_fa = (w_e_fwd_ok && r_rn_q == d_rs) ? ex_alu :
                  (w_m_fwd_ok && m_rn == d_rs)   ? m_data : d_qa;
    assign w_fb = (w_e_fwd_ok && r_rn_q == d_rt) ? ex_alu :
                  (w_m_fwd_ok && m_rn == d_rt)   ? m_data : d_qb;

    assign w_stall  = d_valid & ~flush & w_e_load &
                      ((d_uses_rs & (d_rs == r_rn_q)) | (d_uses_rt & (d_rt == r_rn_q)));
    assign w_bubble = flush | w_stall | ~d_valid;

    always_comb begin
        w_valid_d = 1'b0;
        w_wreg_d  = 1'b0;
        w_m2reg_d = 1'b0;
        w_wmem_d  = 1'b0;
        w_a_d     = '0;
        w_b_d     = '0;
        w_st_d    = '0;
        w_aluc_d  = '0;
        w_rn_d    = '0;
        if (!w_bubble) begin
            w_valid_d = 1'b1;
            w_wreg_d  = d_wreg;
            w_m2reg_d = d_m2reg;
            w_wmem_d  = d_wmem;
            w_a_d     = d_shift ? {27'b0, d_sa} : w_fa;
            w_b_d     = d_aluimm ? d_imm : w_fb;
            w_st_d    = w_fb;
            w_aluc_d  = d_aluc;
            w_rn_d    = d_rn;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid_q <= 1'b0;
            r_wreg_q  <= 1'b0;
            r_m2reg_q <= 1'b0;
            r_wmem_q  <= 1'b0;
            r_a_q     <= '0;
            r_b_q     <= '0;
            r_st_q    <= '0;
            r_aluc_q  <= '0;
            r_rn_q    <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_wreg_q  <= w_wreg_d;
            r_m2reg_q <= w_m2reg_d;
            r_wmem_q  <= w_wmem_d;
            r_a_q     <= w_a_d;
            r_b_q     <= w_b_d;
            r_st_q    <= w_st_d;
            r_aluc_q  <= w_aluc_d;
            r_rn_q    <= w_rn_d;
        end
    end

    assign stall_req = w_stall;
    assign e_valid   = r_valid_q;
    assign e_wreg    = r_wreg_q;
    assign e_m2reg   = r_m2reg_q;
    assign e_wmem    = r_wmem_q;
    assign e_a       = r_a_q;
    assign e_b       = r_b_q;
    assign e_st_data = r_st_q;
    assign e_aluc    = r_aluc_q;
    assign e_rn      = r_rn_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_operand_stage
// Brief    : Scoreboard bench: directed hazard scenarios plus random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_operand_stage;

    localparam int RW = 5;

    typedef struct {
        logic rst, valid;
        logic [31:0] qa, qb, imm;
        logic [4:0] sa;
        logic [3:0] aluc;
        logic [RW-1:0] rs, rt, rn;
        logic urs, urt, aluimm, shift, wreg, m2reg, wmem, flush;
        logic [31:0] ex_alu;
        logic [RW-1:0] m_rn;
        logic m_wreg;
        logic [31:0] m_data;
    } stim_t;

    typedef struct packed {
        logic valid, wreg, m2reg, wmem;
        logic [31:0] a, b;
        logic [3:0] aluc;
        logic [RW-1:0] rn;
        logic [31:0] st;
    } e_t;

    typedef struct {
        logic chk_stall;
        logic stall;
        e_t   nxt;
    } item_t;

    logic clock = 1'b0;
    logic reset, d_valid, d_uses_rs, d_uses_rt, d_aluimm, d_shift;
    logic d_wreg, d_m2reg, d_wmem, flush, m_wreg;
    logic [31:0] d_qa, d_qb, d_imm, ex_alu, m_data;
    logic [4:0] d_sa;
    logic [3:0] d_aluc;
    logic [RW-1:0] d_rs, d_rt, d_rn, m_rn;
    logic stall_req, e_valid, e_wreg, e_m2reg, e_wmem;
    logic [31:0] e_a, e_b, e_st_data;
    logic [3:0] e_aluc;
    logic [RW-1:0] e_rn;

    alu_operand_stage #(.RW(RW)) dut (
        .clock(clock), .reset(reset), .d_valid(d_valid),
        .d_qa(d_qa), .d_qb(d_qb), .d_imm(d_imm), .d_sa(d_sa), .d_aluc(d_aluc),
        .d_rs(d_rs), .d_rt(d_rt), .d_rn(d_rn),
        .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt),
        .d_aluimm(d_aluimm), .d_shift(d_shift),
        .d_wreg(d_wreg), .d_m2reg(d_m2reg), .d_wmem(d_wmem), .flush(flush),
        .ex_alu(ex_alu), .m_rn(m_rn), .m_wreg(m_wreg), .m_data(m_data),
        .stall_req(stall_req), .e_valid(e_valid), .e_wreg(e_wreg),
        .e_m2reg(e_m2reg), .e_wmem(e_wmem), .e_a(e_a), .e_b(e_b),
        .e_aluc(e_aluc), .e_rn(e_rn), .e_st_data(e_st_data)
    );

    always #5 clock = ~clock;

    item_t sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    e_t    me;              // model of what the E register holds
    logic  me_known = 1'b0;

    // Reference: the instruction in E forwards unless it is a load; M otherwise.
    function automatic logic [31:0] fwd(input logic [RW-1:0] r, input logic [31:0] q,
                                        input stim_t s);
        if (me.valid && me.wreg && !me.m2reg && me.rn != 0 && me.rn == r) return s.ex_alu;
        if (s.m_wreg && s.m_rn != 0 && s.m_rn == r) return s.m_data;
        return q;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.valid = 0; s.qa = 0; s.qb = 0; s.imm = 0; s.sa = 0; s.aluc = 0;
        s.rs = 0; s.rt = 0; s.rn = 0; s.urs = 0; s.urt = 0; s.aluimm = 0; s.shift = 0;
        s.wreg = 0; s.m2reg = 0; s.wmem = 0; s.flush = 0; s.ex_alu = 0;
        s.m_rn = 0; s.m_wreg = 0; s.m_data = 0;
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.rst = ($urandom_range(0, 49) == 0); s.valid = ($urandom_range(0, 9) < 8);
        s.qa = $urandom; s.qb = $urandom; s.imm = $urandom;
        s.sa = 5'($urandom); s.aluc = 4'($urandom);
        s.rs = RW'($urandom_range(0, 3)); s.rt = RW'($urandom_range(0, 3));
        s.rn = RW'($urandom_range(0, 3));
        s.urs = 1'($urandom); s.urt = 1'($urandom);
        s.aluimm = ($urandom_range(0, 3) == 0); s.shift = ($urandom_range(0, 3) == 0);
        s.wreg = 1'($urandom); s.m2reg = ($urandom_range(0, 2) == 0); s.wmem = 1'($urandom);
        s.flush = ($urandom_range(0, 9) == 0); s.ex_alu = $urandom;
        s.m_rn = RW'($urandom_range(0, 3)); s.m_wreg = 1'($urandom); s.m_data = $urandom;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        item_t it;
        logic  st;
        e_t    n;
        reset = s.rst; d_valid = s.valid; d_qa = s.qa; d_qb = s.qb; d_imm = s.imm;
        d_sa = s.sa; d_aluc = s.aluc; d_rs = s.rs; d_rt = s.rt; d_rn = s.rn;
        d_uses_rs = s.urs; d_uses_rt = s.urt; d_aluimm = s.aluimm; d_shift = s.shift;
        d_wreg = s.wreg; d_m2reg = s.m2reg; d_wmem = s.wmem; flush = s.flush;
        ex_alu = s.ex_alu; m_rn = s.m_rn; m_wreg = s.m_wreg; m_data = s.m_data;
        st = s.valid && !s.flush && me.valid && me.wreg && me.m2reg && me.rn != 0 &&
             ((s.urs && s.rs == me.rn) || (s.urt && s.rt == me.rn));
        n = '0;
        if (!(s.rst || s.flush || st || !s.valid)) begin
            n.valid = 1'b1; n.wreg = s.wreg; n.m2reg = s.m2reg; n.wmem = s.wmem;
            n.a = s.shift ? 32'(s.sa) : fwd(s.rs, s.qa, s);
            n.b = s.aluimm ? s.imm : fwd(s.rt, s.qb, s);
            n.st = fwd(s.rt, s.qb, s);
            n.aluc = s.aluc; n.rn = s.rn;
        end
        it.chk_stall = me_known; it.stall = st; it.nxt = n;
        sb.push_back(it);
        me = n;
        me_known = me_known | s.rst;
        @(posedge clock); #1;
    endtask

    // Monitor: at each negedge, E outputs reflect the previous popped item's capture.
    initial begin : mon
        item_t it;
        e_t    pend, act;
        logic  have_pend;
        have_pend = 1'b0;
        forever begin
            @(negedge clock);
            if (sb.size() != 0) begin
                it = sb.pop_front();
                act = {e_valid, e_wreg, e_m2reg, e_wmem, e_a, e_b, e_aluc, e_rn, e_st_data};
                if (have_pend) begin
                    n_cmp++;
                    if (act !== pend) begin
                        n_bad++;
                        $display("FAIL e_state @%0t: got %h want %h", $time, act, pend);
                    end
                end
                if (it.chk_stall) begin
                    n_cmp++;
                    if (stall_req !== it.stall) begin
                        n_bad++;
                        $display("FAIL stall_req @%0t: got %b want %b", $time, stall_req, it.stall);
                    end
                end
                pend = it.nxt;
                have_pend = 1'b1;
            end
        end
    end

    initial begin : drv
        stim_t s;
        me = '0;
        @(posedge clock); #1;
        // reset with random decode traffic
        for (int i = 0; i < 2; i++) begin s = rnd(); s.rst = 1; apply(s); end
        // plain capture
        s = idle(); s.valid = 1; s.qa = 5; s.qb = 7; s.rn = 3; s.wreg = 1;
        s.rs = 1; s.rt = 2; s.urs = 1; s.urt = 1; apply(s);
        // add r8 into E, then E-over-M priority, then E holds rn=0 so M wins
        s = idle(); s.valid = 1; s.rn = 8; s.wreg = 1; apply(s);
        s = idle(); s.valid = 1; s.rs = 8; s.urs = 1; s.rn = 0; s.wreg = 1;
        s.ex_alu = 32'h1234; s.m_rn = 8; s.m_wreg = 1; s.m_data = 32'hBEEF; apply(s);
        apply(s);
        // load-use: lw r9, dependent rt=9 stalls, then re-presented with load in M
        s = idle(); s.valid = 1; s.rn = 9; s.wreg = 1; s.m2reg = 1; apply(s);
        s = idle(); s.valid = 1; s.rt = 9; s.urt = 1; s.qb = 32'hDEAD; s.rn = 4; s.wreg = 1;
        s.aluc = 4'h2; apply(s);
        s.m_rn = 9; s.m_wreg = 1; s.m_data = 32'h55; apply(s);
        // shift amount and immediate selection
        s = idle(); s.valid = 1; s.shift = 1; s.sa = 4; s.aluc = 4'b0011; s.qb = 1;
        s.rt = 2; s.urt = 1; s.rn = 5; s.wreg = 1; apply(s);
        s = idle(); s.valid = 1; s.aluimm = 1; s.imm = 32'hFFFF8000; s.qb = 32'h77;
        s.qa = 32'h11; s.rs = 1; s.rt = 2; s.wmem = 1; apply(s);
        // flush wins over a load-use condition
        s = idle(); s.valid = 1; s.rn = 9; s.wreg = 1; s.m2reg = 1; apply(s);
        s = idle(); s.valid = 1; s.rt = 9; s.urt = 1; s.flush = 1; s.rn = 6; s.wreg = 1; apply(s);
        // reset mid-stream with a pending hazard
        s = idle(); s.valid = 1; s.rn = 2; s.wreg = 1; s.m2reg = 1; apply(s);
        s = idle(); s.valid = 1; s.rs = 2; s.urs = 1; s.rst = 1; apply(s);
        s = idle(); s.valid = 1; s.rs = 2; s.urs = 1; s.qa = 9; apply(s);
        // random traffic on a small register set to provoke hazards
        for (int i = 0; i < 400; i++) apply(rnd());
        apply(idle());
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clock);
        if (sb.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_operand_stage.md
# alu_operand_stage

Pipeline register and operand-selection stage directly upstream of the ALU in the pipelined MIPS datapath. It captures decoded instructions and resolves RAW hazards by forwarding from the E and M stages. It detects load-use hazards, requesting a decode stall and inserting a bubble. Its registered outputs drive the ALU `a`, `b` and `aluc` inputs plus the E-stage control bits.

## Interface
- `RW`, default 5: register-number width.
- `clock`, in, 1: single clock; all state updates on rising edge.
- `reset`, in, 1: synchronous, active-high.
- `d_valid`, in, 1: decode slot holds a real instruction.
- `d_qa`, `d_qb`, in, 32: register-file read data for rs and rt.
- `d_imm`, in, 32: extended immediate.
- `d_sa`, in, 5: shift amount.
- `d_aluc`, in, 4: ALU opcode, passed unchanged.
- `d_rs`, `d_rt`, `d_rn`, in, RW: source registers and destination register.
- `d_uses_rs`, `d_uses_rt`, in, 1: instruction actually reads rs or rt.
- `d_aluimm`, `d_shift`, in, 1: select the immediate for b, or the shift amount for a.
- `d_wreg`, `d_m2reg`, `d_wmem`, in, 1: register write, load, and store.
- `flush`, in, 1: squash the decode slot (taken branch/jump).
- `ex_alu`, in, 32: ALU result `s` for the instruction currently in E.
- `m_rn`, in, RW: M-stage destination register.
- `m_wreg`, in, 1: M-stage register-write flag.
- `m_data`, in, 32: resolved M-stage result (ALU result or load data).
- `stall_req`, out, 1: combinational; decode/fetch must hold.
- `e_valid`, `e_wreg`, `e_m2reg`, `e_wmem`, out, 1: registered E-stage flags.
- `e_a`, `e_b`, out, 32: registered ALU operands.
- `e_aluc`, out, 4: registered ALU opcode.
- `e_rn`, out, RW: registered destination register.
- `e_st_data`, out, 32: registered forwarded rt value, used as store data.

## Operation
- Forwarded rs value `fa` (forwarded rt `fb` uses the same rules with rt/`d_qb`):
  - `ex_alu` if `e_valid & e_wreg & ~e_m2reg & e_rn!=0 & e_rn==d_rs`.
  - Else `m_data` if `m_wreg & m_rn!=0 & m_rn==d_rs`.
  - Else `d_qa`.
  - E has priority over M.
- No W-stage forwarding: the register file is write-first.
- Register 0 is never forwarded.
- Operand a = `{27'b0,d_sa}` if `d_shift`, else `fa`.
- Operand b = `d_imm` if `d_aluimm`, else `fb`.
- `e_st_data` = `fb` regardless of `d_aluimm`.
- Load-use hazard: `stall_req = d_valid & ~flush & e_valid & e_wreg & e_m2reg & e_rn!=0 & ((d_uses_rs & d_rs==e_rn) | (d_uses_rt & d_rt==e_rn))`.
- Per-edge update priority:
  1. `reset`: load a bubble.
  2. `flush`: load a bubble.
  3. `stall_req`: load a bubble; decode re-presents the same instruction next cycle.
  4. `~d_valid`: load a bubble.
  5. Otherwise capture operands and controls with `e_valid=1`.
- Bubble contents: all flags 0, `e_aluc=0000` (ADD), `e_a=e_b=e_st_data=0`, `e_rn=0`.
  - A bubble therefore produces ALU `s=0`, `z=1`. Downstream ignores this because `e_wreg=e_wmem=0`.

## Timing
- Reset value of every registered output: 0.
- `stall_req` is 0 whenever outputs hold reset values.
- Latency: decode inputs → E outputs in 1 cycle.
- Forwarding and `stall_req` are combinational from the current inputs and E state, with no internal cycle.
- After a load-use stall, the re-presented instruction finds the load in M and takes `m_data`.
  - The stall lasts exactly 1 cycle.
- `flush` and `stall_req` in the same cycle: `stall_req` is forced 0 and a bubble is inserted.
- Back-to-back writes to the same register from E and M: E value wins.
- `reset` asserted mid-stream: the next edge clears all state. Pending hazards are dropped.

## Test plan
- Reset: hold `reset` 2 cycles with random decode inputs → all `e_*`=0 and `stall_req`=0.
- No hazard: `d_qa=5`, `d_qb=7`, `d_aluc=0000`, `d_rn=3`, `d_wreg=1` → next cycle `e_a=5`, `e_b=7`, `e_rn=3`, `e_valid=1`.
- E forward with priority:
  - Setup: E holds `add r8`, `ex_alu=0x1234`; `m_rn=8`, `m_wreg=1`, `m_data=0xBEEF`.
  - Stimulus: decode `rs=8`, `d_qa=0`.
  - Response: `e_a=0x1234`.
  - Repeat with `e_rn=0` → `e_a=0xBEEF`.
- Load-use:
  - Stimulus: E holds `lw r9`; decode reads `rt=9`, `d_uses_rt=1`.
  - Response: `stall_req=1`; next cycle `e_valid=0`, `e_aluc=0`.
  - Then with `m_rn=9`, `m_data=0x55` → `e_b=0x55`; no second stall.
- Shift/immediate:
  - `d_shift=1`, `d_sa=4`, `d_aluc=0011`, `d_qb=1` → `e_a=4`, `e_b=1`.
  - `d_aluimm=1`, `d_imm=0xFFFF8000` → `e_b=0xFFFF8000`, `e_st_data=fb`.
- Flush over stall: load-use condition and `flush=1` in the same cycle → `stall_req=0`; next cycle a bubble is loaded.
